// File: rtl/vga_fetch.sv
// rtl/vga_fetch.sv - VGA 640x480 timing with centred Mac SE framebuffer byte fetch
//
// Generates registered VGA counters and syncs on the pixel clock. It fetches one
// framebuffer byte per 8 pixels inside the Mac window over a req/ack handshake, and
// hands each byte to the downstream PISO shifter with a one-cycle load strobe.
//
// Ports:
//   clock      in   pixel clock
//   nReset     in   asynchronous active-low reset
//   hSync      out  horizontal sync, active low
//   vSync      out  vertical sync, active low
//   inWindow   out  current pixel lies inside the Mac window
//   vramReq    out  fetch request, held until acked or withdrawn
//   vramAddr   out  byte address, stable while vramReq is high
//   vramAck    in   one-cycle ack; vramData valid in the same cycle
//   vramData   in   fetched byte
//   load       out  one-cycle load strobe for the shifter
//   loadData   out  byte for the shifter (bit 7 = leftmost pixel, 1 = black)
//   underrun   out  one-cycle pulse when a byte missed its load slot
module vga_fetch #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int WIN_X0   = 64,
  parameter int WIN_Y0   = 69,
  parameter int WIN_W    = 512,
  parameter int WIN_H    = 342,
  parameter int ADDR_W   = 15
) (
  input  logic              clock,
  input  logic              nReset,
  output logic              hSync,
  output logic              vSync,
  output logic              inWindow,
  output logic              vramReq,
  output logic [ADDR_W-1:0] vramAddr,
  input  logic              vramAck,
  input  logic [7:0]        vramData,
  output logic              load,
  output logic [7:0]        loadData,
  output logic              underrun
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] HS_LO   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_HI   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_LO   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_HI   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [HW-1:0] X_LO    = HW'(WIN_X0);
  localparam logic [HW-1:0] X_HI    = HW'(WIN_X0 + WIN_W);
  localparam logic [VW-1:0] Y_LO    = VW'(WIN_Y0);
  localparam logic [VW-1:0] Y_HI    = VW'(WIN_Y0 + WIN_H);
  // Each byte is requested one 8-pixel slot ahead of the pixels it paints.
  localparam logic [HW-1:0] REQ_LO  = HW'(WIN_X0 - 8);
  localparam logic [HW-1:0] REQ_HI  = HW'(WIN_X0 - 8 + WIN_W);
  localparam logic [HW-1:0] BLANK_H = HW'(WIN_X0 + WIN_W - 1);

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,  // no request outstanding
    F_WAIT = 2'd1,  // request raised, waiting for ack
    F_HAVE = 2'd2   // byte held in buffer until its load slot
  } fetch_t;

  fetch_t fetchState, fetchNext;

  logic [HW-1:0]     hCount, hNext;
  logic [VW-1:0]     vCount, vNext;
  logic [2:0]        phase;
  logic              lineNext, inReqRange, reqSlot, loadSlot, blankSlot;
  logic              blank, ackTake, dataLoad;
  logic [ADDR_W-1:0] addrCnt;
  logic [7:0]        buffer;

  // Everything registered is decoded from the next counter values so that it
  // lines up with the counters in the same cycle.
  always_comb begin
    hNext = hCount + HW'(1);
    vNext = vCount;
    if (hCount == H_LAST) begin
      hNext = '0;
      vNext = (vCount == V_LAST) ? '0 : vCount + VW'(1);
    end
  end

  assign phase      = hNext[2:0] - REQ_LO[2:0];
  assign lineNext   = (vNext >= Y_LO) && (vNext < Y_HI);
  assign inReqRange = (hNext >= REQ_LO) && (hNext < REQ_HI);
  assign reqSlot    = lineNext && inReqRange && (phase == 3'd0);
  assign loadSlot   = lineNext && inReqRange && (phase == 3'd7);
  assign blankSlot  = lineNext && (hNext == BLANK_H);

  assign vramReq  = (fetchState == F_WAIT);
  assign ackTake  = vramAck && vramReq;
  assign dataLoad = load && !blank;

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) fetchState <= F_IDLE;
    else         fetchState <= fetchNext;
  end

  // A load slot always closes the current request; a new request slot (which
  // can be the very next cycle) always opens one.
  always_comb begin
    fetchNext = fetchState;
    case (fetchState)
      F_WAIT: begin
        if (dataLoad)     fetchNext = F_IDLE;
        else if (ackTake) fetchNext = F_HAVE;
      end
      F_HAVE: if (dataLoad) fetchNext = F_IDLE;
      default: fetchNext = fetchState;
    endcase
    if (reqSlot) fetchNext = F_WAIT;
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      hCount   <= '0;
      vCount   <= '0;
      hSync    <= 1'b1;
      vSync    <= 1'b1;
      inWindow <= 1'b0;
      load     <= 1'b0;
      blank    <= 1'b0;
      vramAddr <= '0;
      addrCnt  <= '0;
      buffer   <= 8'h00;
    end else begin
      hCount   <= hNext;
      vCount   <= vNext;
      hSync    <= !((hNext >= HS_LO) && (hNext < HS_HI));
      vSync    <= !((vNext >= VS_LO) && (vNext < VS_HI));
      inWindow <= lineNext && (hNext >= X_LO) && (hNext < X_HI);
      load     <= loadSlot || blankSlot;
      blank    <= blankSlot;
      if (ackTake) buffer <= vramData;
      if (reqSlot) vramAddr <= addrCnt;
      // The address advances per issued request, acked or not.
      if ((hCount == '0) && (vCount == '0)) addrCnt <= '0;
      else if (reqSlot)                      addrCnt <= addrCnt + ADDR_W'(1);
    end
  end

  // An ack landing in the load cycle itself is forwarded straight through.
  always_comb begin
    loadData = 8'h00;
    underrun = 1'b0;
    if (dataLoad) begin
      if (fetchState == F_HAVE) loadData = buffer;
      else if (ackTake)         loadData = vramData;
      else                      underrun = 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_fetch.sv
// tb/tb_vga_fetch.sv - self-checking bench for vga_fetch
module tb_vga_fetch;

  logic        clock;
  logic        nReset;

  logic        hSync, vSync, inWindow, vramReq, vramAck, load, underrun;
  logic [14:0] vramAddr;
  logic [7:0]  vramData, loadData;
  logic        rAck, forceAck;
  logic [7:0]  rData, fData;

  logic        s_hSync, s_vSync, s_inWindow, s_vramReq, s_vramAck, s_load, s_underrun;
  logic [14:0] s_vramAddr;
  logic [7:0]  s_vramData, s_loadData;

  int unsigned mem [21888];
  int total, bad, t, lat, s_lat, skipAddr;

  assign vramAck  = rAck | forceAck;
  assign vramData = forceAck ? fData : rData;

  vga_fetch dut (
    .clock(clock), .nReset(nReset), .hSync(hSync), .vSync(vSync), .inWindow(inWindow),
    .vramReq(vramReq), .vramAddr(vramAddr), .vramAck(vramAck), .vramData(vramData),
    .load(load), .loadData(loadData), .underrun(underrun)
  );

  // Reduced geometry: 80 x 48 clocks per frame, 32 x 20 window at (16,5).
  vga_fetch #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(40), .V_FP(2), .V_SYNC(2), .V_BP(4),
    .WIN_X0(16), .WIN_Y0(5), .WIN_W(32), .WIN_H(20), .ADDR_W(15)
  ) dut_s (
    .clock(clock), .nReset(nReset), .hSync(s_hSync), .vSync(s_vSync), .inWindow(s_inWindow),
    .vramReq(s_vramReq), .vramAddr(s_vramAddr), .vramAck(s_vramAck), .vramData(s_vramData),
    .load(s_load), .loadData(s_loadData), .underrun(s_underrun)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Memory responders: ack each new request after the programmed latency.
  initial begin : resp_big
    int cnt;
    bit trk;
    logic [14:0] ta;
    rAck = 1'b0; rData = 8'h00; trk = 1'b0; cnt = 0; ta = '0;
    forever begin
      @(posedge clock); #1;
      rAck = 1'b0;
      if (!nReset || !vramReq) trk = 1'b0;
      else begin
        if (!trk || vramAddr != ta) begin trk = 1'b1; ta = vramAddr; cnt = 0; end
        else cnt++;
        if (trk && cnt == lat && int'(ta) != skipAddr) begin
          rAck = 1'b1; rData = 8'(mem[ta]); trk = 1'b0;
        end
      end
    end
  end

  initial begin : resp_small
    int cnt;
    bit trk;
    logic [14:0] ta;
    s_vramAck = 1'b0; s_vramData = 8'h00; trk = 1'b0; cnt = 0; ta = '0;
    forever begin
      @(posedge clock); #1;
      s_vramAck = 1'b0;
      if (!nReset || !s_vramReq) trk = 1'b0;
      else begin
        if (!trk || s_vramAddr != ta) begin trk = 1'b1; ta = s_vramAddr; cnt = 0; end
        else cnt++;
        if (trk && cnt == s_lat) begin
          s_vramAck = 1'b1; s_vramData = 8'(mem[ta]); trk = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    t++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    total++;
    if ({hSync, vSync, inWindow, vramReq, load, underrun, vramAddr, loadData} !==
        {6'b110000, 15'd0, 8'd0}) begin
      bad++;
      $display("FAIL reset_big: got %b want %b",
               {hSync, vSync, inWindow, vramReq, load, underrun, vramAddr, loadData},
               {6'b110000, 15'd0, 8'd0});
    end
    total++;
    if ({s_hSync, s_vSync, s_inWindow, s_vramReq, s_load, s_underrun, s_vramAddr, s_loadData} !==
        {6'b110000, 15'd0, 8'd0}) begin
      bad++;
      $display("FAIL reset_small: got %b want %b",
               {s_hSync, s_vSync, s_inWindow, s_vramReq, s_load, s_underrun, s_vramAddr, s_loadData},
               {6'b110000, 15'd0, 8'd0});
    end
    nReset = 1'b1;
    t = 0;
  endtask

  // Two full frames of the reduced geometry against the timing/fetch rules.
  task automatic test_small_frames();
    int h, v, f, rel, ea;
    int e_sync, e_win, e_load, e_req, e_data, e_und, first;
    int loads[2], hlow[2], vlow[2];
    bit wl, er, el, eb;
    e_sync = 0; e_win = 0; e_load = 0; e_req = 0; e_data = 0; e_und = 0; first = -1;
    for (int i = 0; i < 2; i++) begin loads[i] = 0; hlow[i] = 0; vlow[i] = 0; end
    while (t < 2 * 3840) begin
      h = t % 80; v = (t / 80) % 48; f = t / 3840;
      wl  = (v >= 5) && (v < 25);
      rel = h - 8;
      er  = wl && rel >= 0 && rel < 32 && (rel % 8) == 0;
      el  = wl && rel >= 0 && rel < 32 && (rel % 8) == 7;
      eb  = wl && h == 47;
      ea  = (v - 5) * 4 + (rel >= 0 ? rel / 8 : 0);
      if (s_hSync !== !(h >= 68 && h < 76) || s_vSync !== !(v >= 42 && v < 44)) begin
        e_sync++; if (first < 0) first = t;
      end
      if (s_inWindow !== (wl && h >= 16 && h < 48)) begin e_win++; if (first < 0) first = t; end
      if (s_load !== (el || eb)) begin e_load++; if (first < 0) first = t; end
      if (er && (s_vramReq !== 1'b1 || s_vramAddr !== 15'(ea))) begin
        e_req++; if (first < 0) first = t;
      end
      if ((el && s_loadData !== 8'(mem[ea])) || (eb && s_loadData !== 8'h00)) begin
        e_data++; if (first < 0) first = t;
      end
      if (s_underrun !== 1'b0) begin e_und++; if (first < 0) first = t; end
      if (s_load === 1'b1) loads[f]++;
      if (s_hSync === 1'b0) hlow[f]++;
      if (s_vSync === 1'b0) vlow[f]++;
      if (f == 0 && v == 24 && h == 32) begin
        total++;
        if (s_vramAddr !== 15'd79) begin
          bad++; $display("FAIL small_last_addr: got %0d want 79", s_vramAddr);
        end
      end
      if (f == 1 && v == 5 && h == 8) begin
        total++;
        if (s_vramAddr !== 15'd0 || s_vramReq !== 1'b1) begin
          bad++; $display("FAIL small_wrap_addr: got req=%b addr=%0d want req=1 addr=0",
                          s_vramReq, s_vramAddr);
        end
      end
      tick();
    end
    total++; if (e_sync != 0) begin bad++; $display("FAIL small_sync: got %0d errors want 0 (first t=%0d)", e_sync, first); end
    total++; if (e_win  != 0) begin bad++; $display("FAIL small_window: got %0d errors want 0 (first t=%0d)", e_win, first); end
    total++; if (e_load != 0) begin bad++; $display("FAIL small_load: got %0d errors want 0 (first t=%0d)", e_load, first); end
    total++; if (e_req  != 0) begin bad++; $display("FAIL small_req: got %0d errors want 0 (first t=%0d)", e_req, first); end
    total++; if (e_data != 0) begin bad++; $display("FAIL small_data: got %0d errors want 0 (first t=%0d)", e_data, first); end
    total++; if (e_und  != 0) begin bad++; $display("FAIL small_underrun: got %0d errors want 0 (first t=%0d)", e_und, first); end
    for (int i = 0; i < 2; i++) begin
      total++; if (loads[i] != 100) begin bad++; $display("FAIL small_load_count[%0d]: got %0d want 100", i, loads[i]); end
      total++; if (hlow[i] != 384) begin bad++; $display("FAIL small_hsync_low[%0d]: got %0d want 384", i, hlow[i]); end
      total++; if (vlow[i] != 160) begin bad++; $display("FAIL small_vsync_low[%0d]: got %0d want 160", i, vlow[i]); end
    end
  endtask

  // First window line of the full-size frame, ack latency 2.
  task automatic test_line69();
    int h, n, errs, loads, first;
    bit er, el, eb;
    while (t < 69 * 800) tick();
    errs = 0; loads = 0; first = -1;
    lat = 2;
    repeat (800) begin
      h  = t % 800;
      n  = (h - 56) / 8;
      er = h >= 56 && h <= 560 && ((h - 56) % 8) == 0;
      el = h >= 63 && h <= 567 && ((h - 63) % 8) == 0;
      eb = h == 575;
      if (hSync !== !(h >= 656 && h < 752) || vSync !== 1'b1 ||
          inWindow !== (h >= 64 && h < 576) || load !== (el || eb) || underrun !== 1'b0 ||
          (er && (vramReq !== 1'b1 || vramAddr !== 15'(n))) ||
          (el && loadData !== 8'(mem[(h - 63) / 8])) || (eb && loadData !== 8'h00)) begin
        errs++; if (first < 0) first = h;
      end
      if (load === 1'b1) loads++;
      if (h == 56) begin
        total++;
        if (vramReq !== 1'b1 || vramAddr !== 15'd0) begin
          bad++; $display("FAIL line69_first_req: got req=%b addr=%0d want req=1 addr=0", vramReq, vramAddr);
        end
      end
      if (h == 560) begin
        total++;
        if (vramReq !== 1'b1 || vramAddr !== 15'd63) begin
          bad++; $display("FAIL line69_last_req: got req=%b addr=%0d want req=1 addr=63", vramReq, vramAddr);
        end
      end
      if (h == 63) begin
        total++;
        if (load !== 1'b1 || loadData !== 8'(mem[0])) begin
          bad++; $display("FAIL line69_first_load: got load=%b data=%h want load=1 data=%h", load, loadData, 8'(mem[0]));
        end
      end
      if (h == 575) begin
        total++;
        if (load !== 1'b1 || loadData !== 8'h00) begin
          bad++; $display("FAIL line69_blank_load: got load=%b data=%h want load=1 data=00", load, loadData);
        end
      end
      tick();
    end
    total++; if (errs != 0) begin bad++; $display("FAIL line69_cycles: got %0d errors want 0 (first h=%0d)", errs, first); end
    total++; if (loads != 65) begin bad++; $display("FAIL line69_load_count: got %0d want 65", loads); end
  endtask

  // Ack latency 7: every ack lands in its load cycle and is forwarded.
  task automatic test_late_ack();
    int h, n, errs, fwd, first;
    errs = 0; fwd = 0; first = -1;
    lat = 7;
    repeat (800) begin
      h = t % 800;
      if (h >= 63 && h <= 567 && ((h - 63) % 8) == 0) begin
        n = 64 + (h - 63) / 8;
        if (load !== 1'b1 || loadData !== 8'(mem[n]) || underrun !== 1'b0) begin
          errs++; if (first < 0) first = h;
        end
        if (vramAck === 1'b1) fwd++;
      end else if (underrun !== 1'b0) begin
        errs++; if (first < 0) first = h;
      end
      tick();
    end
    total++; if (errs != 0) begin bad++; $display("FAIL late_ack_data: got %0d errors want 0 (first h=%0d)", errs, first); end
    total++; if (fwd != 64) begin bad++; $display("FAIL late_ack_in_load_cycle: got %0d want 64", fwd); end
  endtask

  // Byte 5 of line 71 (address 133) is never acked.
  task automatic test_missing_ack();
    int h, und;
    und = 0;
    lat = 2;
    skipAddr = 133;
    repeat (800) begin
      h = t % 800;
      if (underrun === 1'b1) und++;
      if (h == 96) begin
        total++;
        if (vramReq !== 1'b1 || vramAddr !== 15'd133) begin
          bad++; $display("FAIL miss_req: got req=%b addr=%0d want req=1 addr=133", vramReq, vramAddr);
        end
      end
      if (h == 103) begin
        total++;
        if ({load, loadData, underrun} !== {1'b1, 8'h00, 1'b1}) begin
          bad++; $display("FAIL miss_load: got load=%b data=%h und=%b want load=1 data=00 und=1", load, loadData, underrun);
        end
      end
      if (h == 104) begin
        total++;
        if (vramReq !== 1'b1 || vramAddr !== 15'd134) begin
          bad++; $display("FAIL miss_next_req: got req=%b addr=%0d want req=1 addr=134", vramReq, vramAddr);
        end
      end
      if (h == 111) begin
        total++;
        if (load !== 1'b1 || loadData !== 8'(mem[134])) begin
          bad++; $display("FAIL miss_recover: got load=%b data=%h want load=1 data=%h", load, loadData, 8'(mem[134]));
        end
      end
      tick();
    end
    skipAddr = -1;
    total++; if (und != 1) begin bad++; $display("FAIL miss_underrun_count: got %0d want 1", und); end
  endtask

  task automatic test_reset_mid();
    int errs, first;
    errs = 0; first = -1;
    lat = 7;
    while ((t % 800) != 300) tick();
    total++;
    if (vramReq !== 1'b1 || vramAddr !== 15'd222) begin
      bad++; $display("FAIL midreset_pre: got req=%b addr=%0d want req=1 addr=222", vramReq, vramAddr);
    end
    nReset = 1'b0;
    #1;
    total++;
    if ({hSync, vSync, inWindow, vramReq, load, underrun, vramAddr, loadData} !==
        {6'b110000, 15'd0, 8'd0}) begin
      bad++;
      $display("FAIL midreset_values: got %b want %b",
               {hSync, vSync, inWindow, vramReq, load, underrun, vramAddr, loadData},
               {6'b110000, 15'd0, 8'd0});
    end
    repeat (3) @(negedge clock);
    nReset = 1'b1;
    lat = 2;
    t = 0;
    fData = 8'($urandom_range(1, 255));
    while (t < 800) begin
      if (vramReq !== 1'b0 || load !== 1'b0 || loadData !== 8'h00 || underrun !== 1'b0 ||
          inWindow !== 1'b0 || vSync !== 1'b1 || hSync !== !(t >= 656 && t < 752)) begin
        errs++; if (first < 0) first = t;
      end
      forceAck = (t == 1);
      tick();
    end
    forceAck = 1'b0;
    total++; if (errs != 0) begin bad++; $display("FAIL midreset_after: got %0d errors want 0 (first t=%0d)", errs, first); end
  endtask

  initial begin
    total = 0; bad = 0; t = 0;
    lat = 2; s_lat = 2; skipAddr = -1;
    forceAck = 1'b0; fData = 8'h00;
    nReset = 1'b0;
    foreach (mem[i]) mem[i] = $urandom;
    test_reset();
    test_small_frames();
    test_line69();
    test_late_ack();
    test_missing_ack();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
